cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Common-data-bus arbiter: shares one result broadcast bus among NUM_SRC functional units (ALU, branch ALU, LS buffer).
//  Each source pushes {tag,data} results into a private FIFO; a round-robin scheduler picks one head per cycle.
//  The picked result is broadcast, registered, to ROB, reservation stations and branch unit.
//  Replaces the single-source ALU-to-CDB register stage once more than one unit writes back.
// PARAMETERS
//  NUM_SRC    3           number of result producers (index 0=ALU, 1=branch ALU, 2=LS buffer)
//  TAG_W      `tagWidth   ROB tag width
//  DATA_W     `dataWidth  result data width
//  FIFO_DEPTH 2           entries per source FIFO (power of two, >=2)
// PORTS
//  clk        in   1                  clock, all state updates on rising edge
//  rst        in   1                  asynchronous, active-low reset
//  flush      in   1                  misprediction flush; discard all buffered results
//  cdb_stall  in   1                  consumer hold-off; no grant while high
//  src_valid  in   NUM_SRC            per-source result valid
//  src_ready  out  NUM_SRC            per-source FIFO can accept (combinational)
//  src_tag    in   NUM_SRC*TAG_W      packed tags, source i at [i*TAG_W +: TAG_W]
//  src_data   in   NUM_SRC*DATA_W     packed results, source i at [i*DATA_W +: DATA_W]
//  cdb_valid  out  1                  broadcast valid (registered)
//  cdb_tag    out  TAG_W              broadcast tag; `tagFree when idle
//  cdb_data   out  DATA_W             broadcast data; 0 when idle
//  cdb_src    out  $clog2(NUM_SRC)    index of broadcasting source; 0 when idle
//  cdb_ack    out  NUM_SRC            one-hot, same cycle as cdb_valid: source's result retired
// BEHAVIOUR
//  Reset (rst=0, async): FIFOs empty, rr pointer=0, cdb_valid=0, cdb_tag=`tagFree, cdb_data=0, cdb_src=0, cdb_ack=0.
//  Push: at edge, source i enqueues iff src_valid[i] && src_ready[i]; src_ready[i] = (count_i<FIFO_DEPTH) && !flush.
//   src_ready uses registered count only: a full FIFO refuses a push even while its head pops this cycle.
//  Arbitration (combinational on FIFO heads): candidates = non-empty FIFOs; if cdb_stall or flush, no grant.
//   Round-robin: search from pointer p upward modulo NUM_SRC; first candidate wins.
//   After a grant to i, p <= (i+1) mod NUM_SRC; no grant leaves p unchanged.
//  Broadcast: winner's head pops at edge and is loaded into output regs; cdb_valid=1, cdb_ack[winner]=1 for exactly one cycle.
//   No grant: outputs return to idle values (valid 0, `tagFree, 0) next edge; nothing holds.
//  Latency: result sampled at edge t appears on CDB after edge t+1 at the earliest (no bypass); throughput 1 result/cycle total.
//  Ordering: per-source FIFO order preserved; no ordering guarantee across sources.
//  Flush: at edge with flush=1 all FIFOs cleared, p<=0, outputs idle; same-edge pushes dropped; broadcast already on bus is not recalled.
//  Wrap-around: FIFO read/write pointers are $clog2(FIFO_DEPTH)+1 bits; full = MSB differ, rest equal; pointer wrap silent.
//  Simultaneous push+pop same FIFO (not full): count unchanged, both take effect.
//  cdb_stall mid-burst: buffered entries retained; sources backpressured via src_ready when full.
//  Invariant: cdb_ack onehot0; cdb_valid==|cdb_ack; cdb_tag==`tagFree iff !cdb_valid.
// STRUCTURE
//  Package/defines: `tagWidth, `dataWidth, `tagFree, source index constants (SRC_ALU, SRC_BR, SRC_LS).
//  Sub-module cdb_src_fifo (TAG_W+DATA_W wide, FIFO_DEPTH deep, push/pop/flush, full/empty/head), one per source via generate.
//  Top: rr-priority encoder function + output register stage.
// TESTING
//  Reset: hold rst=0 with src_valid=3'b111 -> cdb_valid=0, cdb_tag=`tagFree, src_ready=3'b111 after release.
//  Single source: push ALU tag=5 data=32'hDEAD at edge 1 -> after edge 2 cdb_valid=1, tag=5, data=DEAD, cdb_src=0, ack=3'b001.
//  Contention: all three push (tags 1,2,3) same edge, p=0 -> broadcasts tags 1,2,3 on three consecutive cycles, p ends at 0.
//  Backpressure: cdb_stall=1, push ALU 3 times -> 2 accepted, src_ready[0]=0; release stall -> exactly 2 broadcasts in order.
//  Fairness: ALU and LS push every cycle -> grants alternate 0,2,0,2; no source starves.
//  Flush: FIFOs hold 4 entries, flush=1 with concurrent push -> next cycle all empty, cdb idle, no further broadcasts, p=0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: default widths,
// the idle tag value and the fixed source index assignment.
package cdb_arbiter_pkg;

   localparam int TAG_WIDTH  = 6;
   localparam int DATA_WIDTH = 32;

   // Tag value shown on the bus while nothing is broadcast (all ones).
   // Producers never allocate this tag to a real result.
   localparam logic [TAG_WIDTH-1:0] TAG_FREE = '1;

   // Source index assignment on the bus.
   localparam int SRC_ALU = 0;
   localparam int SRC_BR  = 1;
   localparam int SRC_LS  = 2;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter. The caller only
// asserts push when not full and pop when not empty.
module cdb_src_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   // Pointer update; flush drops everything, wrap of the pointers is silent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because the pointers gate reads.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one FIFO per result producer, a round-robin pick
// among non-empty FIFO heads each cycle, and a registered broadcast stage.
// Handshake: a source result transfers at a rising edge when src_valid[i]
// and src_ready[i] are both high; src_ready depends only on the registered
// FIFO fill and on flush, so a full FIFO refuses even while its head pops.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_SRC    = 3,
   parameter int TAG_W      = TAG_WIDTH,
   parameter int DATA_W     = DATA_WIDTH,
   parameter int FIFO_DEPTH = 2,
   parameter int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      cdb_stall,
   input  logic [NUM_SRC-1:0]        src_valid,
   output logic [NUM_SRC-1:0]        src_ready,
   input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_data,
   output logic [SRC_W-1:0]          cdb_src,
   output logic [NUM_SRC-1:0]        cdb_ack
);

   localparam int EW = TAG_W + DATA_W;
   localparam logic [TAG_W-1:0] IDLE_TAG = {TAG_W{TAG_FREE[0]}};

   logic [NUM_SRC-1:0] full;
   logic [NUM_SRC-1:0] empty;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [NUM_SRC-1:0] req;
   logic [EW-1:0]      head [NUM_SRC];
   logic [SRC_W-1:0]   rr_ptr;
   logic [SRC_W-1:0]   rr_next;
   logic [SRC_W:0]     pick;
   logic               grant_valid;
   logic [SRC_W-1:0]   grant_idx;

   // Search upward from ptr (mod NUM_SRC); MSB of the result flags a grant.
   function automatic logic [SRC_W:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                              input logic [SRC_W-1:0]   ptr);
      logic [SRC_W:0] res;
      int             cand;
      res = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = (int'(ptr) + k) % NUM_SRC;
         if (!res[SRC_W] && r[cand]) res = {1'b1, SRC_W'(cand)};
      end
      return res;
   endfunction

   assign src_ready = ~full & {NUM_SRC{~flush}};
   assign push      = src_valid & src_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
         cdb_src_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[gi]),
            .pop   (pop[gi]),
            .din   ({src_tag[gi*TAG_W +: TAG_W], src_data[gi*DATA_W +: DATA_W]}),
            .head  (head[gi]),
            .full  (full[gi]),
            .empty (empty[gi])
         );
      end
   endgenerate

   // Arbitration: pick a winner among non-empty FIFOs unless held off or flushed.
   always_comb begin
      req         = ~empty & {NUM_SRC{~(cdb_stall | flush)}};
      pick        = rr_pick(req, rr_ptr);
      grant_valid = pick[SRC_W];
      grant_idx   = pick[SRC_W-1:0];
      pop         = grant_valid ? (NUM_SRC'(1) << grant_idx) : '0;
      rr_next     = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
   end

   // Broadcast register stage and round-robin pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= IDLE_TAG;
         cdb_data  <= '0;
         cdb_src   <= '0;
         cdb_ack   <= '0;
         rr_ptr    <= '0;
      end else begin
         cdb_ack <= pop;
         if (grant_valid) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= head[grant_idx][EW-1 -: TAG_W];
            cdb_data  <= head[grant_idx][DATA_W-1:0];
            cdb_src   <= grant_idx;
         end else begin
            cdb_valid <= 1'b0;
            cdb_tag   <= IDLE_TAG;
            cdb_data  <= '0;
            cdb_src   <= '0;
         end
         if (flush)            rr_ptr <= '0;
         else if (grant_valid) rr_ptr <= rr_next;
      end
   end

endmodule
